mc_control_unit: RTL
====================

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 Parameter OPW, default 6, width of the opcode field.
REQ-002 Parameter FNW, default 6, width of the funct field.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset; synchronous, active-high.
REQ-005 OPCODE  input  OPW  instruction bits [31:26] from the instruction register.
REQ-006 FUNCT  input  FNW  instruction bits [5:0].
REQ-007 ZERO  input  1  ALU zero flag.
REQ-008 PCEN  output  1  PC register enable.
REQ-009 IORD  output  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-010 MWE  output  1  data memory write enable.
REQ-011 IRWE  output  1  instruction register write enable.
REQ-012 RFWE  output  1  register file write enable.
REQ-013 REGDST  output  1  RF write address select: 0 = rt, 1 = rd.
REQ-014 MTORF  output  1  RF write data select: 0 = ALU result register, 1 = memory data register.
REQ-015 ALUSRCA  output  1  ALU A select: 0 = PC, 1 = RF read port 1.
REQ-016 ALUSRCB  output  2  ALU B select: 00 = RF read port 2, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
REQ-017 PCSRC  output  2  next-PC select: 00 = ALU, 01 = ALU result register, 10 = jump target.
REQ-018 ALUCTRL  output  3  ALU operation code.
REQ-019 ILLEGAL  output  1  one-cycle pulse flagging an unsupported opcode.
REQ-020 STATE  output  4  current state encoding, for debug.

Function
REQ-021 Moore FSM states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-022 Transitions:
- FETCH->DECODE.
- DECODE dispatches on opcode: lw 100011 or sw 101011 -> MEMADR; R-type 000000 -> EXEC; beq 000100 -> BRANCH; addi 001000 -> ADDIEX; j 000010 -> JUMP; any other opcode -> FETCH.
- MEMADR -> MEMRD for lw, MEMWR for sw.
- MEMRD -> MEMWB.
- EXEC -> ALUWB.
- ADDIEX -> ADDIWB.
- MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH.
REQ-023 Encodings 12-15 SHALL transition to FETCH on the next edge.
REQ-024 Outputs asserted per state; every output not listed SHALL be 0:
- FETCH: IRWE=1, PCEN=1, ALUSRCB=01, ALUCTRL=add.
- DECODE: ALUSRCB=11, ALUCTRL=add.
- MEMADR: ALUSRCA=1, ALUSRCB=10, ALUCTRL=add.
- MEMRD: IORD=1.
- MEMWB: RFWE=1, MTORF=1.
- MEMWR: IORD=1, MWE=1.
- EXEC: ALUSRCA=1, ALUCTRL=funct-decoded.
- ALUWB: RFWE=1, REGDST=1.
- BRANCH: ALUSRCA=1, ALUCTRL=sub, PCSRC=01, PCEN=ZERO.
- ADDIEX: ALUSRCA=1, ALUSRCB=10, ALUCTRL=add.
- ADDIWB: RFWE=1.
- JUMP: PCSRC=10, PCEN=1.
REQ-025 ALUCTRL codes: and=000, or=001, add=010, sub=110, slt=111.
REQ-026 Funct decode: 100000 -> add, 100010 -> sub, 100100 -> and, 100101 -> or, 101010 -> slt; any other funct -> add, with the R-type flow unchanged.
REQ-027 ILLEGAL SHALL be 1 for exactly the DECODE cycle in which the opcode is unsupported.
REQ-028 Instruction latency in cycles, FETCH through last state: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-029 RFWE SHALL be asserted only in MEMWB, ALUWB and ADDIWB, and for exactly one cycle per instruction.

Reset
REQ-030 On a rising edge with RST=1, STATE SHALL become FETCH.
REQ-031 While RST=1, PCEN, MWE, IRWE, RFWE and ILLEGAL SHALL be forced to 0; all other outputs SHALL be 0.
REQ-032 Asserting RST mid-instruction SHALL abandon the instruction; the first cycle after RST deasserts SHALL be FETCH.

Structure
REQ-033 Package mc_pkg SHALL hold the state encodings, opcode and funct constants, and ALUCTRL codes.
REQ-034 Funct-to-ALUCTRL decoding SHALL live in the combinational sub-module alu_decoder, instantiated once.

Verification
REQ-035 Reset: RST=1 for 2 cycles with OPCODE=100011 -> STATE=0 and all enables 0 throughout; the first cycle after release shows IRWE=1 and PCEN=1.
REQ-036 lw: OPCODE=100011 -> STATE sequence 0,1,2,3,4; RFWE=1 and MTORF=1 only in state 4.
REQ-037 R-type: OPCODE=000000 with FUNCT=100010 -> ALUCTRL=110 in EXEC; FUNCT=101010 -> 111; FUNCT=111111 -> 010; RFWE=1 with REGDST=1 in ALUWB.
REQ-038 beq: ZERO=1 -> PCEN=1 and PCSRC=01 in BRANCH; ZERO=0 -> PCEN=0; next state FETCH in both cases.
REQ-039 Illegal opcode: OPCODE=111111 -> ILLEGAL=1 for the single DECODE cycle, then STATE=0, with no RFWE or MWE assertion.
REQ-040 Reset mid-instruction: RST=1 during MEMRD of a lw -> no RFWE pulse, and FETCH follows release.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control unit.
// Holds the state encodings, the opcode and funct constants, the ALUCTRL codes
// and the per-state control word used by mc_control_unit.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_ADDIEX = 4'd9,
        ST_ADDIWB = 4'd10,
        ST_JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic       pcen;
        logic       iord;
        logic       mwe;
        logic       irwe;
        logic       rfwe;
        logic       regdst;
        logic       mtorf;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluctrl;
    } ctrl_t;

    // Static control word for a state. The BRANCH PC enable depends on the
    // live ZERO flag and is added outside this function.
    function automatic ctrl_t state_ctrl(input state_e st, input logic [2:0] exec_alu);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH:  begin c.irwe = 1'b1; c.pcen = 1'b1; c.alusrcb = 2'b01; c.aluctrl = ALU_ADD; end
            ST_DECODE: begin c.alusrcb = 2'b11; c.aluctrl = ALU_ADD; end
            ST_MEMADR: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluctrl = ALU_ADD; end
            ST_MEMRD:  c.iord = 1'b1;
            ST_MEMWB:  begin c.rfwe = 1'b1; c.mtorf = 1'b1; end
            ST_MEMWR:  begin c.iord = 1'b1; c.mwe = 1'b1; end
            ST_EXEC:   begin c.alusrca = 1'b1; c.aluctrl = exec_alu; end
            ST_ALUWB:  begin c.rfwe = 1'b1; c.regdst = 1'b1; end
            ST_BRANCH: begin c.alusrca = 1'b1; c.aluctrl = ALU_SUB; c.pcsrc = 2'b01; end
            ST_ADDIEX: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluctrl = ALU_ADD; end
            ST_ADDIWB: c.rfwe = 1'b1;
            ST_JUMP:   begin c.pcsrc = 2'b10; c.pcen = 1'b1; end
            default:   c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Funct-field to ALUCTRL decoder (combinational).
// Ports: funct_i  - R-type funct field
//        aluctrl_o - ALU operation code; unknown funct values fall back to add
module alu_decoder
    import mc_pkg::*;
#(
    parameter int FNW = 6
) (
    input  logic [FNW-1:0] funct_i,
    output logic [2:0]     aluctrl_o
);

    always_comb begin
        aluctrl_o = ALU_ADD;
        case (funct_i)
            FNW'(FN_ADD): aluctrl_o = ALU_ADD;
            FNW'(FN_SUB): aluctrl_o = ALU_SUB;
            FNW'(FN_AND): aluctrl_o = ALU_AND;
            FNW'(FN_OR):  aluctrl_o = ALU_OR;
            FNW'(FN_SLT): aluctrl_o = ALU_SLT;
            default:      aluctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle processor control unit (Moore FSM).
// Inputs : CLK, RST (sync, active-high), OPCODE, FUNCT, ZERO
// Outputs: datapath enables/selects (PCEN, IORD, MWE, IRWE, RFWE, REGDST,
//          MTORF, ALUSRCA, ALUSRCB, PCSRC, ALUCTRL), ILLEGAL pulse, STATE.
//
// state  | meaning
// FETCH  | read instruction, PC += 4
// DECODE | dispatch on opcode, precompute branch target
// MEMADR | compute lw/sw address
// MEMRD  | read data memory
// MEMWB  | write loaded word to RF
// MEMWR  | write data memory
// EXEC   | R-type ALU operation
// ALUWB  | write R-type result to RF
// BRANCH | compare, take branch when ZERO
// ADDIEX | addi ALU operation
// ADDIWB | write addi result to RF
// JUMP   | load jump target into PC
module mc_control_unit
    import mc_pkg::*;
#(
    parameter int OPW = 6,
    parameter int FNW = 6
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [OPW-1:0] OPCODE,
    input  logic [FNW-1:0] FUNCT,
    input  logic           ZERO,
    output logic           PCEN,
    output logic           IORD,
    output logic           MWE,
    output logic           IRWE,
    output logic           RFWE,
    output logic           REGDST,
    output logic           MTORF,
    output logic           ALUSRCA,
    output logic [1:0]     ALUSRCB,
    output logic [1:0]     PCSRC,
    output logic [2:0]     ALUCTRL,
    output logic           ILLEGAL,
    output logic [3:0]     STATE
);

    state_e     state_q, state_d;
    ctrl_t      ctrl_q;
    logic [2:0] fn_alu;
    logic       op_legal;

    alu_decoder #(.FNW(FNW)) u_alu_decoder (
        .funct_i   (FUNCT),
        .aluctrl_o (fn_alu)
    );

    assign op_legal = (OPCODE == OPW'(OP_LW))   || (OPCODE == OPW'(OP_SW))  ||
                      (OPCODE == OPW'(OP_RTYPE)) || (OPCODE == OPW'(OP_BEQ)) ||
                      (OPCODE == OPW'(OP_ADDI)) || (OPCODE == OPW'(OP_J));

    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                if (OPCODE == OPW'(OP_LW) || OPCODE == OPW'(OP_SW)) state_d = ST_MEMADR;
                else if (OPCODE == OPW'(OP_RTYPE))                state_d = ST_EXEC;
                else if (OPCODE == OPW'(OP_BEQ))                  state_d = ST_BRANCH;
                else if (OPCODE == OPW'(OP_ADDI))                 state_d = ST_ADDIEX;
                else if (OPCODE == OPW'(OP_J))                    state_d = ST_JUMP;
                else                                              state_d = ST_FETCH;
            end
            ST_MEMADR: state_d = (OPCODE == OPW'(OP_LW)) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  state_d = ST_MEMWB;
            ST_EXEC:   state_d = ST_ALUWB;
            ST_ADDIEX: state_d = ST_ADDIWB;
            default:   state_d = ST_FETCH;
        endcase
    end

    // The control word is registered alongside the state so it is glitch-free.
    // On reset it is preloaded with the FETCH word so fetch begins the very
    // cycle RST drops; the RST mask below keeps it silent until then.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_FETCH;
            ctrl_q  <= state_ctrl(ST_FETCH, ALU_ADD);
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d, fn_alu);
        end
    end

    // ZERO and OPCODE are only valid in the cycle they are used, so the branch
    // enable and the illegal flag are formed from the live inputs.
    assign PCEN    = ~RST & (ctrl_q.pcen | ((state_q == ST_BRANCH) & ZERO));
    assign IORD    = ~RST & ctrl_q.iord;
    assign MWE     = ~RST & ctrl_q.mwe;
    assign IRWE    = ~RST & ctrl_q.irwe;
    assign RFWE    = ~RST & ctrl_q.rfwe;
    assign REGDST  = ~RST & ctrl_q.regdst;
    assign MTORF   = ~RST & ctrl_q.mtorf;
    assign ALUSRCA = ~RST & ctrl_q.alusrca;
    assign ALUSRCB = RST ? 2'b00 : ctrl_q.alusrcb;
    assign PCSRC   = RST ? 2'b00 : ctrl_q.pcsrc;
    assign ALUCTRL = RST ? 3'b000 : ctrl_q.aluctrl;
    assign ILLEGAL = ~RST & (state_q == ST_DECODE) & ~op_legal;
    assign STATE   = state_q;

endmodule
